mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage, beside the ALU.
- Consumes the same forwarded operands as the ALU.
- Holds the architectural HI/LO registers and supplies MFHI/MFLO data to the EX result mux.
- Drives a busy flag that the hazard unit uses to stall dependent MDU instructions.

Parameters:
- MULT_LATENCY, 5, busy cycles for MULT/MULTU (legal range 1..15).
- DIV_LATENCY, 10, busy cycles for DIV/DIVU (legal range 1..15).

Ports:
- MDU_i_clk  input  1  clock.
- MDU_i_reset  input  1  synchronous, active-high reset.
- MDU_i_Operand1  input  32  rs value (dividend / multiplicand / MT source).
- MDU_i_Operand2  input  32  rt value (divisor / multiplier).
- MDU_i_Operation  input  4  opcode: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9 MADD, 10 MADDU, 11 MSUB, 12 MSUBU; other codes = NOP.
- MDU_i_Start  input  1  a valid MDU instruction is in EX this cycle.
- MDU_i_Cancel  input  1  exception/interrupt flush; blocks state changes this cycle.
- MDU_o_Busy  output  1  computation in progress.
- MDU_o_Result  output  32  combinational read data: HI for MFHI, LO for MFLO, else 0.
- MDU_o_HI  output  32  current HI register.
- MDU_o_LO  output  32  current LO register.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - Reset clears HI, LO, the result temporaries and the counter to 0, and sets the FSM to IDLE, so MDU_o_Busy = 0.
  - Reset during BUSY aborts the operation; HI/LO read 0 in the next cycle.
- FSM states: IDLE, BUSY.
- An "accepted op" requires all of: MDU_i_Start=1, MDU_i_Cancel=0, FSM in IDLE.
- IDLE, on an accepted MULT/MULTU/DIV/DIVU (and MADD-family when enabled):
  - Compute the result into temporaries tHI/tLO.
  - Load the counter with the latency parameter.
  - Go to BUSY.
- BUSY:
  - MDU_o_Busy = 1.
  - The counter decrements each edge.
  - At the edge where the counter equals 1: HI<=tHI, LO<=tLO, go to IDLE.
- Timing: a start sampled at edge k gives Busy=1 in cycles k+1..k+N. New HI/LO and Busy=0 appear together in cycle k+N+1.
- MTHI/MTLO accepted in IDLE: write Operand1 to HI/LO at that edge; no busy phase.
- Ignored while BUSY: any Start. The hazard unit guarantees no Start while busy; the RTL must still ignore it.
- MFHI/MFLO: MDU_o_Result is a combinational read of the current HI/LO, independent of Start and Busy.
- Cancel:
  - Gates only new acceptance.
  - An operation already in BUSY is not aborted, because the instruction already committed past EX.
- Arithmetic:
  - MULT: signed 32x32 to 64-bit product; {HI,LO} = product.
  - MULTU: unsigned 32x32 to 64-bit product; {HI,LO} = product.
  - DIV: quotient truncated toward zero to LO; remainder to HI, with the sign of the dividend.
  - DIVU: unsigned quotient to LO, remainder to HI.
  - Overflow wraps silently: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divisor = 0 (DIV/DIVU): still runs the full DIV_LATENCY busy phase; HI/LO are left unchanged at completion.
- Back-to-back: a new Start may be accepted in the very cycle Busy first reads 0 (cycle k+N+1).

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: opcodes 9..12 are accepted with MULT_LATENCY.
  - MADD: {HI,LO} += signed product.
  - MADDU: {HI,LO} += unsigned product.
  - MSUB: {HI,LO} -= signed product.
  - MSUBU: {HI,LO} -= unsigned product.
  - All modulo 2^64.
  - The accumulate base is the {HI,LO} value at the accept edge.
- Undefined: opcodes 9..12 decode as NOP (no busy, no register change), and no accumulator adder is synthesized.

Test Plan:
- Reset, then MULT with Operand1=0xFFFFFFFD (-3), Operand2=5 -> Busy high for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1; MFHI gives Result=0xFFFFFFFF.
- MULTU 0xFFFFFFFF x 2 -> after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE; HI/LO hold their old values during busy.
- DIV -7/2 (0xFFFFFFF9, 2) -> 10 busy cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 -> LO=3, HI=1.
- MTHI 0x12345678, then DIVU 9/0 -> Busy 10 cycles; afterwards HI=0x12345678 and LO unchanged.
- Start MULT with Cancel=1 -> Busy stays 0 and HI/LO are unchanged. Start DIV, then assert reset at busy cycle 4 -> next cycle Busy=0, HI=LO=0.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, then MADDU 1x1 -> HI=1, LO=0. Without the macro, the same stimulus leaves HI=0, LO=0xFFFFFFFF and Busy=0.

Source files
------------

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Optional MADD/MADDU/MSUB/MSUBU accumulate ops are built when MDU_MADD_EN is defined.
module mult_div_unit #(
  parameter int MULT_LATENCY = 5,
  parameter int DIV_LATENCY  = 10
) (
  input  logic        MDU_i_clk,
  input  logic        MDU_i_reset,
  input  logic [31:0] MDU_i_Operand1,
  input  logic [31:0] MDU_i_Operand2,
  input  logic [3:0]  MDU_i_Operation,
  input  logic        MDU_i_Start,
  input  logic        MDU_i_Cancel,
  output logic        MDU_o_Busy,
  output logic [31:0] MDU_o_Result,
  output logic [31:0] MDU_o_HI,
  output logic [31:0] MDU_o_LO
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  localparam logic [3:0] MULT_LAT = 4'(MULT_LATENCY);
  localparam logic [3:0] DIV_LAT  = 4'(DIV_LATENCY);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] thi_q, thi_d;
  logic [31:0] tlo_q, tlo_d;

  logic        accept_s;
  logic        mul_signed_s;
  logic [63:0] mul_a_s, mul_b_s, prod_s;
  logic        div_signed_s, div_a_neg_s, div_b_neg_s;
  logic [31:0] div_a_mag_s, div_b_mag_s, div_b_safe_s;
  logic [31:0] q_mag_s, r_mag_s, quo_s, rem_s;
  logic [31:0] result_s;
`ifdef MDU_MADD_EN
  logic [63:0] acc_s;
`endif

  // Shared arithmetic datapath: one 64-bit multiplier fed with sign- or zero-extended operands,
  // and a magnitude divider whose signs are restored afterwards.
  always_comb begin
`ifdef MDU_MADD_EN
    mul_signed_s = (MDU_i_Operation == OP_MULT) || (MDU_i_Operation == OP_MADD) ||
                   (MDU_i_Operation == OP_MSUB);
`else
    mul_signed_s = (MDU_i_Operation == OP_MULT);
`endif
    mul_a_s = {{32{mul_signed_s & MDU_i_Operand1[31]}}, MDU_i_Operand1};
    mul_b_s = {{32{mul_signed_s & MDU_i_Operand2[31]}}, MDU_i_Operand2};
    prod_s  = mul_a_s * mul_b_s;

    div_signed_s = (MDU_i_Operation == OP_DIV);
    div_a_neg_s  = div_signed_s & MDU_i_Operand1[31];
    div_b_neg_s  = div_signed_s & MDU_i_Operand2[31];
    div_a_mag_s  = div_a_neg_s ? (32'd0 - MDU_i_Operand1) : MDU_i_Operand1;
    div_b_mag_s  = div_b_neg_s ? (32'd0 - MDU_i_Operand2) : MDU_i_Operand2;
    // A zero divisor is steered to 1 only to keep the divider defined; its result is discarded.
    if (MDU_i_Operand2 == 32'd0) begin
      div_b_safe_s = 32'd1;
    end else begin
      div_b_safe_s = div_b_mag_s;
    end
    q_mag_s = div_a_mag_s / div_b_safe_s;
    r_mag_s = div_a_mag_s % div_b_safe_s;
    quo_s   = (div_a_neg_s ^ div_b_neg_s) ? (32'd0 - q_mag_s) : q_mag_s;
    rem_s   = div_a_neg_s ? (32'd0 - r_mag_s) : r_mag_s;

`ifdef MDU_MADD_EN
    if ((MDU_i_Operation == OP_MSUB) || (MDU_i_Operation == OP_MSUBU)) begin
      acc_s = {hi_q, lo_q} - prod_s;
    end else begin
      acc_s = {hi_q, lo_q} + prod_s;
    end
`endif
  end

  // Next-state logic for the IDLE/BUSY sequencer, HI/LO and the result temporaries.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    thi_d    = thi_q;
    tlo_d    = tlo_q;
    accept_s = MDU_i_Start & ~MDU_i_Cancel & (state_q == IDLE);

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          case (MDU_i_Operation)
            OP_MULT, OP_MULTU: begin
              thi_d   = prod_s[63:32];
              tlo_d   = prod_s[31:0];
              cnt_d   = MULT_LAT;
              state_d = BUSY;
            end
            OP_DIV, OP_DIVU: begin
              if (MDU_i_Operand2 == 32'd0) begin
                thi_d = hi_q;
                tlo_d = lo_q;
              end else begin
                thi_d = rem_s;
                tlo_d = quo_s;
              end
              cnt_d   = DIV_LAT;
              state_d = BUSY;
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
              thi_d   = acc_s[63:32];
              tlo_d   = acc_s[31:0];
              cnt_d   = MULT_LAT;
              state_d = BUSY;
            end
`endif
            OP_MTHI: hi_d = MDU_i_Operand1;
            OP_MTLO: lo_d = MDU_i_Operand1;
            default: begin
              hi_d = hi_q;
            end
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd1) begin
          hi_d    = thi_q;
          lo_d    = tlo_q;
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge MDU_i_clk) begin
    if (MDU_i_reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      thi_q   <= 32'd0;
      tlo_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      thi_q   <= thi_d;
      tlo_q   <= tlo_d;
    end
  end

  // MFHI/MFLO read path is combinational and independent of Start/Busy.
  always_comb begin
    case (MDU_i_Operation)
      OP_MFHI: result_s = hi_q;
      OP_MFLO: result_s = lo_q;
      default: result_s = 32'd0;
    endcase
  end

  assign MDU_o_Busy   = (state_q == BUSY);
  assign MDU_o_Result = result_s;
  assign MDU_o_HI     = hi_q;
  assign MDU_o_LO     = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (default latencies 5/10).
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] op1 = 32'd0;
  logic [31:0] op2 = 32'd0;
  logic [3:0]  oper = 4'd0;
  logic        start = 1'b0;
  logic        cancel = 1'b0;
  logic        busy;
  logic [31:0] result, hi, lo;

  int tests_run = 0;
  int tests_failed = 0;

  mult_div_unit dut (
    .MDU_i_clk(clk), .MDU_i_reset(reset), .MDU_i_Operand1(op1), .MDU_i_Operand2(op2),
    .MDU_i_Operation(oper), .MDU_i_Start(start), .MDU_i_Cancel(cancel),
    .MDU_o_Busy(busy), .MDU_o_Result(result), .MDU_o_HI(hi), .MDU_o_LO(lo)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an op for exactly one edge; returns #1 after that edge.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    oper = o; op1 = a; op2 = b; start = 1'b1;
    step();
    start = 1'b0; oper = 4'd0;
  endtask

  // Counts cycles with Busy high, bounded so a stuck DUT cannot hang the run.
  task automatic run_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; step(); step(); reset = 1'b0;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %0b want 0", busy); end
    tests_run++; if (hi !== 32'd0) begin tests_failed++; $display("FAIL reset_hi got %h want 0", hi); end
    tests_run++; if (lo !== 32'd0) begin tests_failed++; $display("FAIL reset_lo got %h want 0", lo); end
    tests_run++; if (result !== 32'd0) begin tests_failed++; $display("FAIL reset_result got %h want 0", result); end
  endtask

  task automatic test_mult();
    int n;
    issue(4'd1, 32'hFFFFFFFD, 32'd5);
    run_busy(n);
    tests_run++; if (n !== 5) begin tests_failed++; $display("FAIL mult_busy_cycles got %0d want 5", n); end
    tests_run++; if (hi !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL mult_hi got %h want ffffffff", hi); end
    tests_run++; if (lo !== 32'hFFFFFFF1) begin tests_failed++; $display("FAIL mult_lo got %h want fffffff1", lo); end
    oper = 4'd5; #1;
    tests_run++; if (result !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL mfhi got %h want ffffffff", result); end
    oper = 4'd6; #1;
    tests_run++; if (result !== 32'hFFFFFFF1) begin tests_failed++; $display("FAIL mflo got %h want fffffff1", result); end
    oper = 4'd0;
  endtask

  task automatic test_multu();
    int n;
    issue(4'd2, 32'hFFFFFFFF, 32'd2);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL multu_busy_start got %0b want 1", busy); end
    step(); step();
    tests_run++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1) begin
      tests_failed++; $display("FAIL multu_hold got %h_%h want ffffffff_fffffff1", hi, lo); end
    run_busy(n);
    tests_run++; if (n !== 3) begin tests_failed++; $display("FAIL multu_busy_rest got %0d want 3", n); end
    tests_run++; if (hi !== 32'h00000001 || lo !== 32'hFFFFFFFE) begin
      tests_failed++; $display("FAIL multu_result got %h_%h want 00000001_fffffffe", hi, lo); end
  endtask

  task automatic test_div();
    int n;
    issue(4'd3, 32'hFFFFFFF9, 32'd2);
    run_busy(n);
    tests_run++; if (n !== 10) begin tests_failed++; $display("FAIL div_busy_cycles got %0d want 10", n); end
    tests_run++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
      tests_failed++; $display("FAIL div_neg got %h_%h want ffffffff_fffffffd", hi, lo); end
    issue(4'd4, 32'd7, 32'd2);
    run_busy(n);
    tests_run++; if (hi !== 32'd1 || lo !== 32'd3) begin
      tests_failed++; $display("FAIL divu got %h_%h want 00000001_00000003", hi, lo); end
  endtask

  // New op issued in the very cycle Busy drops; also covers signed overflow wrap.
  task automatic test_back_to_back();
    int n;
    issue(4'd1, 32'd6, 32'd7);
    run_busy(n);
    issue(4'd3, 32'h80000000, 32'hFFFFFFFF);
    tests_run++; if (hi !== 32'd0 || lo !== 32'd42) begin
      tests_failed++; $display("FAIL b2b_first got %h_%h want 00000000_0000002a", hi, lo); end
    run_busy(n);
    tests_run++; if (n !== 10) begin tests_failed++; $display("FAIL b2b_busy_cycles got %0d want 10", n); end
    tests_run++; if (hi !== 32'd0 || lo !== 32'h80000000) begin
      tests_failed++; $display("FAIL div_overflow got %h_%h want 00000000_80000000", hi, lo); end
  endtask

  task automatic test_divzero();
    int n;
    issue(4'd7, 32'h12345678, 32'd0);
    tests_run++; if (hi !== 32'h12345678 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL mthi got %h busy %0b want 12345678 busy 0", hi, busy); end
    issue(4'd4, 32'd9, 32'd0);
    run_busy(n);
    tests_run++; if (n !== 10) begin tests_failed++; $display("FAIL divzero_busy got %0d want 10", n); end
    tests_run++; if (hi !== 32'h12345678 || lo !== 32'h80000000) begin
      tests_failed++; $display("FAIL divzero_hold got %h_%h want 12345678_80000000", hi, lo); end
    issue(4'd8, 32'hCAFEF00D, 32'd0);
    tests_run++; if (lo !== 32'hCAFEF00D) begin tests_failed++; $display("FAIL mtlo got %h want cafef00d", lo); end
  endtask

  task automatic test_cancel();
    int n;
    cancel = 1'b1;
    issue(4'd1, 32'd3, 32'd4);
    cancel = 1'b0;
    tests_run++; if (busy !== 1'b0 || hi !== 32'h12345678 || lo !== 32'hCAFEF00D) begin
      tests_failed++; $display("FAIL cancel_block got busy %0b %h_%h want 0 12345678_cafef00d", busy, hi, lo); end
    issue(4'd2, 32'd3, 32'd4);
    cancel = 1'b1; step(); cancel = 1'b0;
    run_busy(n);
    tests_run++; if (n !== 4) begin tests_failed++; $display("FAIL cancel_no_abort got %0d want 4", n); end
    tests_run++; if (hi !== 32'd0 || lo !== 32'd12) begin
      tests_failed++; $display("FAIL cancel_busy_result got %h_%h want 00000000_0000000c", hi, lo); end
  endtask

  task automatic test_busy_ignore();
    int n;
    issue(4'd4, 32'd100, 32'd7);
    issue(4'd7, 32'hDEADBEEF, 32'd0);
    run_busy(n);
    tests_run++; if (n !== 9) begin tests_failed++; $display("FAIL ignore_busy got %0d want 9", n); end
    tests_run++; if (hi !== 32'd2 || lo !== 32'd14) begin
      tests_failed++; $display("FAIL ignore_result got %h_%h want 00000002_0000000e", hi, lo); end
  endtask

  task automatic test_reset_abort();
    issue(4'd3, 32'd100, 32'd7);
    step(); step(); step();
    reset = 1'b1; step(); reset = 1'b0;
    tests_run++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      tests_failed++; $display("FAIL reset_abort got busy %0b %h_%h want 0 0_0", busy, hi, lo); end
    step();
    tests_run++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      tests_failed++; $display("FAIL reset_abort_stay got busy %0b %h_%h want 0 0_0", busy, hi, lo); end
  endtask

  task automatic test_madd();
    int n;
    issue(4'd7, 32'd0, 32'd0);
    issue(4'd8, 32'hFFFFFFFF, 32'd0);
    issue(4'd10, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
    run_busy(n);
    tests_run++; if (n !== 5) begin tests_failed++; $display("FAIL maddu_busy got %0d want 5", n); end
    tests_run++; if (hi !== 32'd1 || lo !== 32'd0) begin
      tests_failed++; $display("FAIL maddu got %h_%h want 00000001_00000000", hi, lo); end
    issue(4'd11, 32'hFFFFFFFF, 32'd1);
    run_busy(n);
    tests_run++; if (hi !== 32'd1 || lo !== 32'd1) begin
      tests_failed++; $display("FAIL msub got %h_%h want 00000001_00000001", hi, lo); end
`else
    n = 0;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL maddu_nop_busy got %0b want 0", busy); end
    step();
    tests_run++; if (hi !== 32'd0 || lo !== 32'hFFFFFFFF) begin
      tests_failed++; $display("FAIL maddu_nop got %h_%h want 00000000_ffffffff", hi, lo); end
`endif
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_back_to_back();
    test_divzero();
    test_cancel();
    test_busy_ignore();
    test_reset_abort();
    test_madd();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
